fetch_queue: RTL
================

# fetch_queue

Parametrised instruction fetch buffer between instruction memory and decode. It replaces the single-entry fetch latch with a DEPTH-entry FIFO of {pc, inst} pairs, so fetch can run ahead of a stalled decoder. It keeps the existing stall/branch semantics: downstream stall propagates upstream only when the queue is full, and a taken branch flushes every buffered entry. Successive fetches are decoupled from decode stalls by up to DEPTH instructions.

## Interface
- WORD, 32, instruction width in bits
- ADDR, 32, PC width in bits
- DEPTH, 4, number of entries; power of two, >= 2
- CNTW, $clog2(DEPTH+1), width of occupancy count

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clk
- v_i  input  1  fetch side presents a valid {pc_i, inst_i} this cycle
- pc_i  input  ADDR  PC of the presented instruction
- inst_i  input  WORD  presented instruction word
- stall_o  output  1  back-pressure to fetch; push not accepted this cycle
- v_o  output  1  head entry valid toward decode
- pc_o  output  ADDR  PC of head entry
- inst_o  output  WORD  instruction of head entry
- stall_i  input  1  decode stall; head not consumed this cycle
- branch_i  input  1  taken branch/redirect; flush all entries
- count_o  output  CNTW  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH × (ADDR+WORD) register array, read pointer rd, write pointer wr, occupancy cnt; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- full = (cnt == DEPTH); empty = (cnt == 0).
- pop = v_o & ~stall_i.
- stall_o = full & stall_i (combinational). A full queue still accepts a push in the same cycle as a pop.
- push = v_i & ~stall_o & ~branch_i.
- On push, write {pc_i, inst_i} at wr and advance wr by 1.
- On pop, advance rd by 1.
- cnt update: cnt + push − pop. Simultaneous push and pop leaves cnt unchanged. Push into empty with no pop gives cnt = 1.
- v_o = ~empty. When v_o = 0, pc_o and inst_o are driven to 0. When v_o = 1, they show the entry at rd.
- Flush: when branch_i = 1 at a clock edge, the next state is rd = wr = 0 and cnt = 0.
  - Any push in that cycle is dropped.
  - Pop in that cycle is irrelevant.
  - Branch has priority over push and pop.
- Reset (reset = 0 at edge): rd = wr = cnt = 0. Reset has priority over branch_i, push and pop. Asserting reset mid-operation discards all entries. Array contents need not be cleared.
- Order is strict FIFO, including across pointer wrap-around.

## Timing
- Reset values of outputs: v_o = 0, pc_o = 0, inst_o = 0, count_o = 0, stall_o = 0 (since not full).
- Push latency: an entry pushed at edge N appears on v_o/pc_o/inst_o after edge N. There is no same-cycle bypass from input to output.
- stall_o depends combinationally on stall_i and registered cnt only. There is no combinational path from v_i or branch_i to stall_o.
- Flush: after the edge where branch_i = 1, v_o = 0 and count_o = 0. A push in the following cycle is accepted normally.
- Throughput: one push and one pop per cycle sustained at any occupancy.
- count_o is registered and reflects the state after the last edge.

## Test plan
- Reset then fill, DEPTH=4, stall_i = 1:
  - Stimulus: push pc 0x00, 0x04, 0x08, 0x0C.
  - Required: count_o goes 1, 2, 3, 4; stall_o = 1 once count_o = 4; a fifth push of pc 0x10 is ignored; pc_o stays 0x00.
- Drain in order:
  - Stimulus: from full, set stall_i = 0 with v_i = 0.
  - Required: pc_o = 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then v_o = 0 with pc_o = 0 and inst_o = 0.
- Full with simultaneous push and pop:
  - Stimulus: full, stall_i = 0, v_i = 1 with pc 0x10.
  - Required: stall_o = 0 and the push is accepted; count_o stays 4; 0x10 emerges after 0x0C.
- Wrap-around under sustained traffic:
  - Stimulus: 20 consecutive pushes with pc 4·k while stall_i toggles 1, 0.
  - Required: outputs are exactly pc 4·k in order with no loss or duplication; count_o never exceeds 4.
- Branch flush:
  - Stimulus: count_o = 3, assert branch_i together with v_i = 1 (pc 0x40).
  - Required: next cycle v_o = 0, count_o = 0, and 0x40 is not stored; a push of 0x80 the following cycle appears next on pc_o.
- Reset mid-operation:
  - Stimulus: count_o = 2, drive reset = 0 for one edge with v_i = 1 and branch_i = 0.
  - Required: after that edge all outputs are at reset values; no entry survives.

Source files
------------

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Groups the fetch-side and decode-side signals of the instruction fetch
// queue into one bundle.
//   slave  : the queue's view (fetch inputs and decode stall/branch in;
//            back-pressure, head entry and occupancy out)
//   master : the environment's view (fetch and decode sides)
// Signals:
//   v_i, pc_i, inst_i : fetch presents {pc, inst}
//   stall_o           : back-pressure to fetch
//   v_o, pc_o, inst_o : head entry toward decode
//   stall_i           : decode stall
//   branch_i          : taken branch, flush all entries
//   count_o           : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned WORD = 32,
    parameter int unsigned ADDR = 32,
    parameter int unsigned CNTW = 3
);
    logic            v_i;
    logic [ADDR-1:0] pc_i;
    logic [WORD-1:0] inst_i;
    logic            stall_o;
    logic            v_o;
    logic [ADDR-1:0] pc_o;
    logic [WORD-1:0] inst_o;
    logic            stall_i;
    logic            branch_i;
    logic [CNTW-1:0] count_o;

    modport slave (
        input  v_i, pc_i, inst_i, stall_i, branch_i,
        output stall_o, v_o, pc_o, inst_o, count_o
    );

    modport master (
        output v_i, pc_i, inst_i, stall_i, branch_i,
        input  stall_o, v_o, pc_o, inst_o, count_o
    );
endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry FIFO of {pc, inst} pairs between instruction memory and decode.
// Fetch runs ahead of a stalled decoder until the queue is full; a taken
// branch flushes every buffered entry.
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous active-low reset
//   fq     : fetch_queue_if.slave bundle (see interface header)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned WORD  = 32,
    parameter int unsigned ADDR  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    fetch_queue_if.slave     fq
);
    localparam int unsigned PTRW = $clog2(DEPTH);

    logic [ADDR-1:0] r_pc   [DEPTH];
    logic [WORD-1:0] r_inst [DEPTH];
    logic [PTRW-1:0] r_rd;
    logic [PTRW-1:0] r_wr;
    logic [CNTW-1:0] r_cnt;

    logic w_full;
    logic w_empty;
    logic w_stall;
    logic w_push;
    logic w_pop;

    always_comb begin
        w_full  = (r_cnt == CNTW'(DEPTH));
        w_empty = (r_cnt == '0);
        // Back-pressure only when full and decode is not draining this cycle;
        // a full queue still takes a push alongside a pop.
        w_stall = w_full & fq.stall_i;
        w_pop   = ~w_empty & ~fq.stall_i;
        w_push  = fq.v_i & ~w_stall & ~fq.branch_i;
    end

    // Pointers and occupancy; reset beats branch, branch beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (fq.branch_i) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTRW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNTW'(1);
                2'b01:   r_cnt <= r_cnt - CNTW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by r_cnt alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr]   <= fq.pc_i;
            r_inst[r_wr] <= fq.inst_i;
        end
    end

    always_comb begin
        fq.stall_o = w_stall;
        fq.v_o     = ~w_empty;
        fq.count_o = r_cnt;
        fq.pc_o    = w_empty ? '0 : r_pc[r_rd];
        fq.inst_o  = w_empty ? '0 : r_inst[r_rd];
    end
endmodule
